// File: rtl/pipeline_ctrl.sv
// ============================================================================
// pipeline_ctrl
// ----------------------------------------------------------------------------
// Hazard and sequencing controller for a 5-stage RV32I pipeline. It drives
// the decode stage's stop/bubble inputs and the fetch stage's PC-hold and
// flush controls. The controller:
//   - detects load-use hazards on the instruction waiting in IF/ID,
//   - inserts bubbles and flushes IF/ID after taken branches and jumps,
//   - freezes the whole pipeline while the memory stage is busy.
//
// Optional build macro: PIPE_CTRL_PERF_EN
//   defined     -> 32-bit wrapping performance counters stall_cnt/flush_cnt
//   not defined -> no counter flops, both counter outputs tied to 0
//
// Parameters:
//   LOAD_LAT      bubble cycles per load-use hazard        (1..7)
//   FLUSH_CYCLES  bubble/flush cycles per EX redirect      (1..7)
//
// Ports:
//   clk          in   1   system clock, rising edge
//   reset        in   1   synchronous active-high reset
//   id_command   in  32   instruction in IF/ID
//   ex_reg_d     in   5   destination register of the ID/EX instruction
//   ex_is_load   in   1   ID/EX instruction is a load
//   ex_redirect  in   1   EX resolved a taken branch / jal / jalr
//   mem_busy     in   1   memory stage cannot complete this cycle
//   stop         out  1   freeze all pipeline registers
//   bubble       out  1   decode captures a nop at the next edge
//   pc_hold      out  1   fetch keeps PC and IF/ID contents
//   if_flush     out  1   fetch invalidates IF/ID, loads redirect target
//   ctrl_state   out  2   0 RUN, 1 LOAD_STALL, 2 FLUSH
//   stall_cnt    out 32   stall-cycle performance counter
//   flush_cnt    out 32   flush-cycle performance counter
// ============================================================================
module pipeline_ctrl #(
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] id_command,
    input  logic [4:0]  ex_reg_d,
    input  logic        ex_is_load,
    input  logic        ex_redirect,
    input  logic        mem_busy,
    output logic        stop,
    output logic        bubble,
    output logic        pc_hold,
    output logic        if_flush,
    output logic [1:0]  ctrl_state,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_LOAD_STALL = 2'd1;
    localparam logic [1:0] ST_FLUSH      = 2'd2;

    // Counter start values: the detection cycle itself is the first bubble,
    // so the non-RUN state only has to cover the remaining N-1 cycles.
    localparam logic [2:0] LOAD_INIT  = 3'(LOAD_LAT - 1);
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [1:0] r_state;
    logic [2:0] r_cnt;
    logic [1:0] w_state_next;
    logic [2:0] w_cnt_next;

    logic       w_stop;
    logic       w_bubble;
    logic       w_pc_hold;
    logic       w_if_flush;

    // ------------------------------------------------------------------------
    // Operand-usage decode and load-use hazard detection
    // ------------------------------------------------------------------------
    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic       w_rs1_used;
    logic       w_rs2_used;
    logic       w_hazard;

    assign w_opcode = id_command[6:0];
    assign w_funct3 = id_command[14:12];
    assign w_rs1    = id_command[19:15];
    assign w_rs2    = id_command[24:20];

    // Bits of the instruction that play no part in operand usage.
    logic w_unused_bits;
    assign w_unused_bits = ^{id_command[31:25], id_command[11:7]};

    always_comb begin
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
        case (w_opcode)
            OP_JALR, OP_LOAD, OP_IMM: w_rs1_used = 1'b1;
            OP_BRANCH, OP_STORE, OP_OP: begin
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
            end
            // Register-form CSR ops read rs1; ecall/ebreak (funct3 0) and
            // the immediate forms (funct3[2] set) carry no register source.
            OP_SYSTEM: w_rs1_used = (w_funct3 != 3'b000) && !w_funct3[2];
            default: begin
                w_rs1_used = 1'b0;
                w_rs2_used = 1'b0;
            end
        endcase
    end

    // x0 is hard-wired to zero, so a load into it never creates a hazard.
    assign w_hazard = ex_is_load && (ex_reg_d != 5'd0) &&
                      ((w_rs1_used && (w_rs1 == ex_reg_d)) ||
                       (w_rs2_used && (w_rs2 == ex_reg_d)));

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // Priority: reset > mem_busy > ex_redirect > hazard > counter.
    // ------------------------------------------------------------------------
    always_comb begin
        w_stop       = 1'b0;
        w_bubble     = 1'b0;
        w_pc_hold    = 1'b0;
        w_if_flush   = 1'b0;
        w_state_next = r_state;
        w_cnt_next   = r_cnt;

        if (reset) begin
            // Outputs forced quiet; state is cleared by the register block.
            w_state_next = ST_RUN;
            w_cnt_next   = 3'd0;
        end else if (mem_busy) begin
            // Whole pipeline frozen: state and counter hold, and a pending
            // redirect is held by its source until mem_busy falls.
            w_stop    = 1'b1;
            w_pc_hold = 1'b1;
        end else if (ex_redirect) begin
            // Taken from any state: aborts a load stall and restarts an
            // ongoing flush.
            w_bubble   = 1'b1;
            w_if_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                w_state_next = ST_FLUSH;
                w_cnt_next   = FLUSH_INIT;
            end else begin
                w_state_next = ST_RUN;
                w_cnt_next   = 3'd0;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_hazard) begin
                        w_bubble  = 1'b1;
                        w_pc_hold = 1'b1;
                        if (LOAD_LAT > 1) begin
                            w_state_next = ST_LOAD_STALL;
                            w_cnt_next   = LOAD_INIT;
                        end
                    end
                end
                ST_LOAD_STALL: begin
                    w_bubble  = 1'b1;
                    w_pc_hold = 1'b1;
                    if (r_cnt <= 3'd1) begin
                        w_state_next = ST_RUN;
                        w_cnt_next   = 3'd0;
                    end else begin
                        w_cnt_next = r_cnt - 3'd1;
                    end
                end
                ST_FLUSH: begin
                    w_bubble   = 1'b1;
                    w_if_flush = 1'b1;
                    if (r_cnt <= 3'd1) begin
                        w_state_next = ST_RUN;
                        w_cnt_next   = 3'd0;
                    end else begin
                        w_cnt_next = r_cnt - 3'd1;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to RUN.
                    w_state_next = ST_RUN;
                    w_cnt_next   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    assign stop       = w_stop;
    assign bubble     = w_bubble;
    assign pc_hold    = w_pc_hold;
    assign if_flush   = w_if_flush;
    assign ctrl_state = reset ? ST_RUN : r_state;

    // ------------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------------
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (w_stop || (w_pc_hold && w_bubble))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_if_flush)
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
// tb_pipeline_ctrl
// ----------------------------------------------------------------------------
// Two controller instances share the clock and reset: dut_a (LOAD_LAT=1,
// FLUSH_CYCLES=2) and dut_b (LOAD_LAT=4, FLUSH_CYCLES=2). Each directed
// vector drives one instance while the other sits idle. The driver pushes
// the hand-computed expectation for both instances into a queue; a monitor
// on the falling edge pops and compares against the live outputs.
// ============================================================================
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        reset;

    logic [31:0] a_cmd, b_cmd;
    logic [4:0]  a_rd, b_rd;
    logic        a_ld, b_ld, a_redir, b_redir, a_busy, b_busy;

    logic        a_stop, a_bubble, a_pc_hold, a_if_flush;
    logic        b_stop, b_bubble, b_pc_hold, b_if_flush;
    logic [1:0]  a_state, b_state;
    logic [31:0] a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt;

    always #5 clk = ~clk;

    pipeline_ctrl #(.LOAD_LAT(1), .FLUSH_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset), .id_command(a_cmd), .ex_reg_d(a_rd),
        .ex_is_load(a_ld), .ex_redirect(a_redir), .mem_busy(a_busy),
        .stop(a_stop), .bubble(a_bubble), .pc_hold(a_pc_hold),
        .if_flush(a_if_flush), .ctrl_state(a_state),
        .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    pipeline_ctrl #(.LOAD_LAT(4), .FLUSH_CYCLES(2)) dut_b (
        .clk(clk), .reset(reset), .id_command(b_cmd), .ex_reg_d(b_rd),
        .ex_is_load(b_ld), .ex_redirect(b_redir), .mem_busy(b_busy),
        .stop(b_stop), .bubble(b_bubble), .pc_hold(b_pc_hold),
        .if_flush(b_if_flush), .ctrl_state(b_state),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    // Instruction encodings used by the vectors
    localparam logic [31:0] NOP       = 32'h0000_0013; // addi x0,x0,0
    localparam logic [31:0] ADDI_X5   = 32'h0012_8313; // addi x6,x5,1
    localparam logic [31:0] ADDI_X0   = 32'h0010_0313; // addi x6,x0,1
    localparam logic [31:0] LUI_B5    = 32'h0002_8337; // lui x6, bits[19:15]=5
    localparam logic [31:0] ADD_RS2   = 32'h0050_83B3; // add x7,x1,x5
    localparam logic [31:0] SW_RS2    = 32'h0051_2023; // sw x5,0(x2)
    localparam logic [31:0] CSRRW_X5  = 32'h0002_9073; // csrrw x0,0,x5
    localparam logic [31:0] SYS_F0    = 32'h0002_8073; // system funct3=0, rs1 field 5
    localparam logic [31:0] CSRRWI_5  = 32'h0002_D073; // csrrwi (immediate form)
    localparam logic [31:0] JAL_B5    = 32'h0002_806F; // jal, bits[19:15]=5

    typedef struct {
        string      name;
        logic [3:0] exp_a;   // {stop, bubble, pc_hold, if_flush}
        logic [1:0] st_a;
        logic [3:0] exp_b;
        logic [1:0] st_b;
        logic       chk_perf;
        logic [31:0] exp_fc;
        logic [31:0] exp_sc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   done     = 1'b0;

    // ------------------------------------------------------------------------
    // Monitor: compares outputs away from the rising edge
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [3:0] got_a, got_b;
            e     = sb.pop_front();
            got_a = {a_stop, a_bubble, a_pc_hold, a_if_flush};
            got_b = {b_stop, b_bubble, b_pc_hold, b_if_flush};
            n_checks++;
            if (got_a == e.exp_a && a_state == e.st_a) begin
                n_pass++;
                $display("ok   %s A out=%b st=%0d", e.name, got_a, a_state);
            end else
                $display("FAIL %s A out=%b st=%0d expected out=%b st=%0d",
                         e.name, got_a, a_state, e.exp_a, e.st_a);
            n_checks++;
            if (got_b == e.exp_b && b_state == e.st_b) begin
                n_pass++;
                $display("ok   %s B out=%b st=%0d", e.name, got_b, b_state);
            end else
                $display("FAIL %s B out=%b st=%0d expected out=%b st=%0d",
                         e.name, got_b, b_state, e.exp_b, e.st_b);
            if (e.chk_perf) begin
                n_checks++;
                if (a_flush_cnt == e.exp_fc && a_stall_cnt == e.exp_sc) begin
                    n_pass++;
                    $display("ok   %s perf flush=%0d stall=%0d",
                             e.name, a_flush_cnt, a_stall_cnt);
                end else
                    $display("FAIL %s perf flush=%0d stall=%0d expected flush=%0d stall=%0d",
                             e.name, a_flush_cnt, a_stall_cnt, e.exp_fc, e.exp_sc);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Driver: one vector per cycle, applied just after the rising edge
    // ------------------------------------------------------------------------
    task automatic step(input string name, input logic rst, input logic sel_b,
                        input logic [31:0] cmd, input logic [4:0] rd,
                        input logic ld, input logic redir, input logic busy,
                        input logic [3:0] exp_o, input logic [1:0] exp_st);
        exp_t e;
        @(posedge clk);
        #1;
        reset   = rst;
        a_cmd   = sel_b ? NOP : cmd;   b_cmd   = sel_b ? cmd : NOP;
        a_rd    = sel_b ? 5'd0 : rd;   b_rd    = sel_b ? rd : 5'd0;
        a_ld    = sel_b ? 1'b0 : ld;   b_ld    = sel_b ? ld : 1'b0;
        a_redir = sel_b ? 1'b0 : redir; b_redir = sel_b ? redir : 1'b0;
        a_busy  = sel_b ? 1'b0 : busy; b_busy  = sel_b ? busy : 1'b0;
        e.name     = name;
        e.exp_a    = sel_b ? 4'b0000 : exp_o;
        e.st_a     = sel_b ? 2'd0 : exp_st;
        e.exp_b    = sel_b ? exp_o : 4'b0000;
        e.st_b     = sel_b ? exp_st : 2'd0;
        e.chk_perf = 1'b0;
        e.exp_fc   = 32'd0;
        e.exp_sc   = 32'd0;
        sb.push_back(e);
    endtask

    // Same as an idle A step, but also checks dut_a's performance counters.
    task automatic perf_step(input string name, input logic [31:0] fc,
                             input logic [31:0] sc);
        step(name, 1'b0, 1'b0, NOP, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0);
        sb[sb.size()-1].chk_perf = 1'b1;
`ifdef PIPE_CTRL_PERF_EN
        sb[sb.size()-1].exp_fc = fc;
        sb[sb.size()-1].exp_sc = sc;
`else
        sb[sb.size()-1].exp_fc = 32'd0;
        sb[sb.size()-1].exp_sc = 32'd0;
        if (fc == sc) begin end
`endif
    endtask

    initial begin
        reset = 1'b1;
        a_cmd = NOP; b_cmd = NOP; a_rd = 5'd0; b_rd = 5'd0;
        a_ld = 1'b0; b_ld = 1'b0; a_redir = 1'b0; b_redir = 1'b0;
        a_busy = 1'b0; b_busy = 1'b0;
        repeat (2) @(posedge clk);

        // Reset holds outputs quiet even with active inputs
        step("rst_quiet_a", 1, 0, ADDI_X5, 5'd5, 1, 1, 0, 4'b0000, 2'd0);
        step("rst_quiet_b", 1, 1, ADDI_X5, 5'd5, 1, 0, 1, 4'b0000, 2'd0);
        step("after_rst",   0, 0, NOP, 5'd0, 0, 0, 0, 4'b0000, 2'd0);

        // Load-use detection, LOAD_LAT=1
        step("lu_rs1",      0, 0, ADDI_X5, 5'd5, 1, 0, 0, 4'b0110, 2'd0);
        step("lu_rs1_done", 0, 0, NOP,     5'd0, 0, 0, 0, 4'b0000, 2'd0);
        step("x0_dest",     0, 0, ADDI_X0, 5'd0, 1, 0, 0, 4'b0000, 2'd0);
        step("no_load",     0, 0, ADDI_X5, 5'd5, 0, 0, 0, 4'b0000, 2'd0);
        step("lui_unused",  0, 0, LUI_B5,  5'd5, 1, 0, 0, 4'b0000, 2'd0);
        step("add_rs2",     0, 0, ADD_RS2, 5'd5, 1, 0, 0, 4'b0110, 2'd0);
        step("sw_rs2",      0, 0, SW_RS2,  5'd5, 1, 0, 0, 4'b0110, 2'd0);
        step("csrrw_rs1",   0, 0, CSRRW_X5,5'd5, 1, 0, 0, 4'b0110, 2'd0);
        step("sys_f0",      0, 0, SYS_F0,  5'd5, 1, 0, 0, 4'b0000, 2'd0);
        step("csrrwi",      0, 0, CSRRWI_5,5'd5, 1, 0, 0, 4'b0000, 2'd0);
        step("jal_unused",  0, 0, JAL_B5,  5'd5, 1, 0, 0, 4'b0000, 2'd0);
        step("rd_mismatch", 0, 0, ADDI_X5, 5'd6, 1, 0, 0, 4'b0000, 2'd0);

        // Redirect, FLUSH_CYCLES=2: state 0 -> 2 -> 0
        step("redir_c1",    0, 0, NOP, 5'd0, 0, 1, 0, 4'b0101, 2'd0);
        step("redir_c2",    0, 0, NOP, 5'd0, 0, 0, 0, 4'b0101, 2'd2);
        step("redir_done",  0, 0, NOP, 5'd0, 0, 0, 0, 4'b0000, 2'd0);

        // Redirect plus hazard together, then mem_busy mid-flush
        step("redir_haz",   0, 0, ADDI_X5, 5'd5, 1, 1, 0, 4'b0101, 2'd0);
        step("busy_1",      0, 0, NOP, 5'd0, 0, 0, 1, 4'b1010, 2'd2);
        step("busy_2",      0, 0, NOP, 5'd0, 0, 0, 1, 4'b1010, 2'd2);
        step("busy_3",      0, 0, NOP, 5'd0, 0, 0, 1, 4'b1010, 2'd2);
        step("flush_resume",0, 0, NOP, 5'd0, 0, 0, 0, 4'b0101, 2'd2);
        step("flush_end",   0, 0, NOP, 5'd0, 0, 0, 0, 4'b0000, 2'd0);

        // Redirect during FLUSH restarts the flush
        step("rf_c1",       0, 0, NOP, 5'd0, 0, 1, 0, 4'b0101, 2'd0);
        step("rf_restart",  0, 0, NOP, 5'd0, 0, 1, 0, 4'b0101, 2'd2);
        step("rf_last",     0, 0, NOP, 5'd0, 0, 0, 0, 4'b0101, 2'd2);
        step("rf_done",     0, 0, NOP, 5'd0, 0, 0, 0, 4'b0000, 2'd0);

        // LOAD_LAT=4: exactly four bubble cycles
        step("l4_detect",   0, 1, ADDI_X5, 5'd5, 1, 0, 0, 4'b0110, 2'd0);
        step("l4_s1",       0, 1, NOP, 5'd0, 0, 0, 0, 4'b0110, 2'd1);
        step("l4_s2",       0, 1, NOP, 5'd0, 0, 0, 0, 4'b0110, 2'd1);
        step("l4_s3",       0, 1, NOP, 5'd0, 0, 0, 0, 4'b0110, 2'd1);
        step("l4_done",     0, 1, NOP, 5'd0, 0, 0, 0, 4'b0000, 2'd0);

        // Reset mid-LOAD_STALL
        step("rs_detect",   0, 1, ADDI_X5, 5'd5, 1, 0, 0, 4'b0110, 2'd0);
        step("rs_s1",       0, 1, NOP, 5'd0, 0, 0, 0, 4'b0110, 2'd1);
        step("rs_s2",       0, 1, NOP, 5'd0, 0, 0, 0, 4'b0110, 2'd1);
        step("rs_reset",    1, 1, NOP, 5'd0, 0, 0, 0, 4'b0000, 2'd0);
        step("rs_after",    0, 1, NOP, 5'd0, 0, 0, 0, 4'b0000, 2'd0);

        // Redirect aborts a load stall
        step("ab_detect",   0, 1, ADDI_X5, 5'd5, 1, 0, 0, 4'b0110, 2'd0);
        step("ab_redir",    0, 1, NOP, 5'd0, 0, 1, 0, 4'b0101, 2'd1);
        step("ab_flush",    0, 1, NOP, 5'd0, 0, 0, 0, 4'b0101, 2'd2);
        step("ab_done",     0, 1, NOP, 5'd0, 0, 0, 0, 4'b0000, 2'd0);

        // mem_busy inside a stall is not counted as a bubble cycle
        step("bs_detect",   0, 1, ADDI_X5, 5'd5, 1, 0, 0, 4'b0110, 2'd0);
        step("bs_busy",     0, 1, NOP, 5'd0, 0, 0, 1, 4'b1010, 2'd1);
        step("bs_s1",       0, 1, NOP, 5'd0, 0, 0, 0, 4'b0110, 2'd1);
        step("bs_s2",       0, 1, NOP, 5'd0, 0, 0, 0, 4'b0110, 2'd1);
        step("bs_s3",       0, 1, NOP, 5'd0, 0, 0, 0, 4'b0110, 2'd1);
        step("bs_done",     0, 1, NOP, 5'd0, 0, 0, 0, 4'b0000, 2'd0);

        // Performance counters: redirect (2 flush cycles) then 1-cycle stall
        step("pf_reset",    1, 0, NOP, 5'd0, 0, 0, 0, 4'b0000, 2'd0);
        step("pf_redir",    0, 0, NOP, 5'd0, 0, 1, 0, 4'b0101, 2'd0);
        step("pf_flush",    0, 0, NOP, 5'd0, 0, 0, 0, 4'b0101, 2'd2);
        step("pf_stall",    0, 0, ADDI_X5, 5'd5, 1, 0, 0, 4'b0110, 2'd0);
        perf_step("pf_counts", 32'd2, 32'd1);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_checks++;
            $display("FAIL drain %0d entries left expected 0", sb.size());
        end
        @(posedge clk);
        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Absolute time bound in case the driver ever stalls
    initial begin
        #100000;
        if (!done) begin
            $display("FAIL timeout sim did not complete expected completion");
            $fatal(1, "timeout");
        end
    end

endmodule
